// File: rtl/bram_heap_ctrl_pkg.sv
// Shared types and tree-index helpers for the BRAM-resident min-heap sequencer.
package bram_heap_pkg;

    // Command opcode carried on i_op.
    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_e;

    // Sequencer states: idle, sift-up (read parent / compare) and sift-down
    // (fetch last element / read left / read right / compare).
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_RD   = 3'd1,
        UP_CMP  = 3'd2,
        DN_LAST = 3'd3,
        DN_RDL  = 3'd4,
        DN_RDR  = 3'd5,
        DN_CMP  = 3'd6
    } state_e;

    // Index helpers work on a generous fixed width; callers size-cast the
    // result to their own address width (child indices keep one extra bit).
    localparam int IDX_W = 32;

    // Parent of node i: (i-1)>>1. Only meaningful for i > 0.
    function automatic logic [IDX_W-1:0] heap_parent(input logic [IDX_W-1:0] i);
        return (i - 32'd1) >> 1;
    endfunction

    // Left child of node i: 2i+1.
    function automatic logic [IDX_W-1:0] heap_left(input logic [IDX_W-1:0] i);
        return (i << 1) + 32'd1;
    endfunction

    // Right child of node i: 2i+2.
    function automatic logic [IDX_W-1:0] heap_right(input logic [IDX_W-1:0] i);
        return (i << 1) + 32'd2;
    endfunction

endpackage

// File: rtl/bram_heap_ctrl_comparator.sv
// Three-way compare-swap: decides whether a parent key must trade places with
// the smaller of its two children. Child ties pick the right child; a parent
// equal to the smaller child stays put.
module comparator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] parent,
    input  logic [DATA_WIDTH-1:0] left,
    input  logic [DATA_WIDTH-1:0] right,
    output logic [DATA_WIDTH-1:0] parent_out,
    output logic                  sel_right
);

    logic [DATA_WIDTH-1:0] min_child_s;

    // Pick the smaller child, then keep the parent unless that child is strictly smaller.
    always_comb begin
        sel_right   = 1'b0;
        min_child_s = left;
        parent_out  = parent;
        if (right <= left) begin
            sel_right   = 1'b1;
            min_child_s = right;
        end else begin
            sel_right   = 1'b0;
            min_child_s = left;
        end
        if (parent > min_child_s) begin
            parent_out = min_child_s;
        end else begin
            parent_out = parent;
        end
    end

endmodule

// File: rtl/bram_heap_ctrl.sv
// Binary min-heap sequencer: accepts enqueue/dequeue commands and walks the
// tree in an inferred single-read/single-write memory one level at a time.
module bram_heap_ctrl
    import bram_heap_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CAPACITY   = 1023,
    localparam int ADDR_WIDTH = $clog2(CAPACITY + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_op,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [ADDR_WIDTH-1:0] o_size,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] A_CAP  = ADDR_WIDTH'(CAPACITY);
    localparam logic [DATA_WIDTH-1:0] D_ONES = {DATA_WIDTH{1'b1}};

    // Heap storage; deliberately never cleared.
    logic [DATA_WIDTH-1:0] mem [0:CAPACITY-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    state_e                state_r,     state_s;
    logic [ADDR_WIDTH-1:0] size_r,      size_s;
    logic [ADDR_WIDTH-1:0] cur_idx_r,   cur_idx_s;
    logic [DATA_WIDTH-1:0] cur_val_r,   cur_val_s;
    logic [DATA_WIDTH-1:0] left_r,      left_s;
    logic                  right_ok_r,  right_ok_s;
    logic [DATA_WIDTH-1:0] root_r,      root_s;
    logic [DATA_WIDTH-1:0] out_data_r,  out_data_s;
    logic                  out_valid_r, out_valid_s;
    logic                  err_r,       err_s;

    logic                  rd_en_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    // Child indices carry one extra bit so 2i+2 never wraps past the size bound.
    logic [ADDR_WIDTH:0]   left_idx_s;
    logic [ADDR_WIDTH:0]   right_idx_s;
    logic [ADDR_WIDTH-1:0] parent_idx_s;
    logic [DATA_WIDTH-1:0] right_val_s;
    logic [DATA_WIDTH-1:0] cmp_parent_s;
    logic                  cmp_sel_right_s;

    assign left_idx_s   = (ADDR_WIDTH + 1)'(heap_left(IDX_W'(cur_idx_r)));
    assign right_idx_s  = (ADDR_WIDTH + 1)'(heap_right(IDX_W'(cur_idx_r)));
    assign parent_idx_s = ADDR_WIDTH'(heap_parent(IDX_W'(cur_idx_r)));
    // A missing right child is presented as the largest key so it never wins.
    assign right_val_s  = right_ok_r ? rdata_r : D_ONES;

    comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .parent     (cur_val_r),
        .left       (left_r),
        .right      (right_val_s),
        .parent_out (cmp_parent_s),
        .sel_right  (cmp_sel_right_s)
    );

    // Next-state, memory port and output decode for the heap sequencer.
    always_comb begin
        state_s     = state_r;
        size_s      = size_r;
        cur_idx_s   = cur_idx_r;
        cur_val_s   = cur_val_r;
        left_s      = left_r;
        right_ok_s  = right_ok_r;
        root_s      = root_r;
        out_data_s  = out_data_r;
        out_valid_s = 1'b0;
        err_s       = 1'b0;
        rd_en_s     = 1'b0;
        rd_addr_s   = A_ZERO;
        wr_en_s     = 1'b0;
        wr_addr_s   = A_ZERO;
        wr_data_s   = {DATA_WIDTH{1'b0}};

        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    if (op_e'(i_op) == OP_ENQ) begin
                        if (size_r == A_CAP) begin
                            err_s = 1'b1;
                        end else if (size_r == A_ZERO) begin
                            wr_en_s   = 1'b1;
                            wr_addr_s = A_ZERO;
                            wr_data_s = i_data;
                            size_s    = A_ONE;
                        end else begin
                            cur_val_s = i_data;
                            cur_idx_s = size_r;
                            size_s    = size_r + A_ONE;
                            state_s   = UP_RD;
                        end
                    end else begin
                        if (size_r == A_ZERO) begin
                            err_s = 1'b1;
                        end else begin
                            out_data_s  = root_r;
                            out_valid_s = 1'b1;
                            size_s      = size_r - A_ONE;
                            rd_en_s     = 1'b1;
                            rd_addr_s   = size_r - A_ONE;
                            state_s     = DN_LAST;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            UP_RD: begin
                if (cur_idx_r == A_ZERO) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = A_ZERO;
                    wr_data_s = cur_val_r;
                    state_s   = IDLE;
                end else begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = parent_idx_s;
                    state_s   = UP_CMP;
                end
            end

            UP_CMP: begin
                // Only a strictly larger parent moves down; equal keys stay.
                if (rdata_r > cur_val_r) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_idx_r;
                    wr_data_s = rdata_r;
                    cur_idx_s = parent_idx_s;
                    state_s   = UP_RD;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_idx_r;
                    wr_data_s = cur_val_r;
                    state_s   = IDLE;
                end
            end

            DN_LAST: begin
                cur_val_s = rdata_r;
                cur_idx_s = A_ZERO;
                if (size_r == A_ZERO) begin
                    state_s = IDLE;
                end else begin
                    state_s = DN_RDL;
                end
            end

            DN_RDL: begin
                if (left_idx_s >= {1'b0, size_r}) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_idx_r;
                    wr_data_s = cur_val_r;
                    state_s   = IDLE;
                end else begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = left_idx_s[ADDR_WIDTH-1:0];
                    state_s   = DN_RDR;
                end
            end

            DN_RDR: begin
                left_s = rdata_r;
                if (right_idx_s < {1'b0, size_r}) begin
                    rd_en_s    = 1'b1;
                    rd_addr_s  = right_idx_s[ADDR_WIDTH-1:0];
                    right_ok_s = 1'b1;
                end else begin
                    right_ok_s = 1'b0;
                end
                state_s = DN_CMP;
            end

            DN_CMP: begin
                if (cmp_parent_s == cur_val_r) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_idx_r;
                    wr_data_s = cur_val_r;
                    state_s   = IDLE;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cur_idx_r;
                    wr_data_s = cmp_parent_s;
                    if (cmp_sel_right_s) begin
                        cur_idx_s = right_idx_s[ADDR_WIDTH-1:0];
                    end else begin
                        cur_idx_s = left_idx_s[ADDR_WIDTH-1:0];
                    end
                    state_s = DN_RDL;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        // The cached root follows every write to address 0.
        if (wr_en_s && (wr_addr_s == A_ZERO)) begin
            root_s = wr_data_s;
        end else begin
            root_s = root_r;
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            size_r      <= A_ZERO;
            cur_idx_r   <= A_ZERO;
            cur_val_r   <= {DATA_WIDTH{1'b0}};
            left_r      <= {DATA_WIDTH{1'b0}};
            right_ok_r  <= 1'b0;
            root_r      <= {DATA_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            size_r      <= size_s;
            cur_idx_r   <= cur_idx_s;
            cur_val_r   <= cur_val_s;
            left_r      <= left_s;
            right_ok_r  <= right_ok_s;
            root_r      <= root_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
            err_r       <= err_s;
        end
    end

    // Inferred block RAM: one synchronous read and one write per cycle.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
        if (rd_en_s) begin
            rdata_r <= mem[rd_addr_s];
        end
    end

    assign o_ready = (state_r == IDLE);
    assign o_valid = out_valid_r;
    assign o_data  = out_data_r;
    assign o_err   = err_r;
    assign o_min   = root_r;
    assign o_size  = size_r;
    assign o_empty = (size_r == A_ZERO);
    assign o_full  = (size_r == A_CAP);

endmodule

// File: tb/tb_bram_heap_ctrl.sv
// Self-checking bench for bram_heap_ctrl: directed scenarios followed by a
// randomized command stream checked against a priority-queue reference.
module tb_bram_heap_ctrl;

    localparam int DW  = 8;
    localparam int CAP = 15;
    localparam int AW  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_op = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_ready, o_valid, o_err, o_empty, o_full;
    logic [DW-1:0] o_data, o_min;
    logic [AW-1:0] o_size;

    int tests = 0;
    int fails = 0;
    int model[$];   // reference multiset of keys currently in the queue

    bram_heap_ctrl #(.DATA_WIDTH(DW), .CAPACITY(CAP)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_err   (o_err),
        .o_min   (o_min),
        .o_size  (o_size),
        .o_empty (o_empty),
        .o_full  (o_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        model.delete();
    endtask

    // Present one command for one cycle; returns one cycle after acceptance.
    task automatic issue(input logic op, input logic [DW-1:0] d);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 32'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_data  = d;
        step();
        i_valid = 1'b0;
    endtask

    // Counts cycles with o_ready low, starting at the cycle after acceptance.
    task automatic wait_idle(output int busy);
        busy = 0;
        while (!o_ready && busy < 50) begin
            step();
            busy++;
        end
        chk("idle_timeout", 32'(busy < 50), 32'd1);
    endtask

    function automatic int model_min();
        int m;
        m = model[0];
        foreach (model[k]) if (model[k] < m) m = model[k];
        return m;
    endfunction

    function automatic void model_pop_min();
        int m;
        m = model_min();
        foreach (model[k]) begin
            if (model[k] == m) begin
                model.delete(k);
                break;
            end
        end
    endfunction

    task automatic enq(input logic [DW-1:0] d);
        int b;
        issue(1'b0, d);
        model.push_back(int'(d));
        wait_idle(b);
    endtask

    // One randomized command with full checking against the reference.
    task automatic rand_op(input int enq_weight);
        logic          op;
        logic [DW-1:0] d;
        logic          exp_err;
        int            busy;
        int            exp_min;
        op = ($urandom_range(0, 99) < enq_weight) ? 1'b0 : 1'b1;
        d  = ($urandom_range(0, 15) == 0) ? 8'hff : 8'($urandom_range(0, 31));
        exp_err = op ? (model.size() == 0) : (model.size() == CAP);
        exp_min = (model.size() != 0) ? model_min() : 0;
        issue(op, d);
        chk("rnd_err", 32'(o_err), 32'(exp_err));
        chk("rnd_valid", 32'(o_valid), 32'(op && !exp_err));
        if (op && !exp_err) begin
            chk("rnd_data", 32'(o_data), 32'(exp_min));
            model_pop_min();
        end else if (!op && !exp_err) begin
            model.push_back(int'(d));
        end else begin
            // rejected command leaves the reference untouched
        end
        chk("rnd_size_t1", 32'(o_size), 32'(model.size()));
        wait_idle(busy);
        if (!op) chk("rnd_enq_busy_bound", 32'(busy <= 9), 32'd1);
        else     chk("rnd_deq_busy_bound", 32'(busy <= 11), 32'd1);
        chk("rnd_size", 32'(o_size), 32'(model.size()));
        chk("rnd_empty", 32'(o_empty), 32'(model.size() == 0));
        chk("rnd_full", 32'(o_full), 32'(model.size() == CAP));
        if (model.size() != 0) chk("rnd_min", 32'(o_min), 32'(model_min()));
    endtask

    initial begin
        int busy;
        int exp_seq[5];
        exp_seq = '{1, 3, 5, 7, 9};

        // Reset values.
        step();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_min", 32'(o_min), 32'd0);
        chk("rst_size", 32'(o_size), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        do_reset();

        // Enqueue into empty heap: no busy cycles.
        issue(1'b0, 8'd5);
        chk("enq_empty_ready", 32'(o_ready), 32'd1);
        chk("enq_empty_min", 32'(o_min), 32'd5);
        chk("enq_empty_size", 32'(o_size), 32'd1);

        // Heap {10}, enqueue 3: three busy cycles then root 3.
        do_reset();
        enq(8'd10);
        issue(1'b0, 8'd3);
        wait_idle(busy);
        chk("enq3_busy", 32'(busy), 32'd3);
        chk("enq3_min", 32'(o_min), 32'd3);
        chk("enq3_mem0", 32'(dut.mem[0]), 32'd3);
        chk("enq3_mem1", 32'(dut.mem[1]), 32'd10);

        // Sorted drain of 7,3,9,1,5.
        do_reset();
        enq(8'd7); enq(8'd3); enq(8'd9); enq(8'd1); enq(8'd5);
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 8'd0);
            chk("drain_valid", 32'(o_valid), 32'd1);
            chk("drain_data", 32'(o_data), 32'(exp_seq[k]));
            chk("drain_size_t1", 32'(o_size), 32'(4 - k));
            wait_idle(busy);
            if (k == 0) chk("drain_first_busy", 32'(busy), 32'd7);
            if (k == 4) chk("drain_last_busy", 32'(busy), 32'd1);
            chk("drain_valid_drop", 32'(o_valid), 32'(busy == 0));
        end
        chk("drain_empty", 32'(o_empty), 32'd1);

        // Dequeue when empty.
        issue(1'b1, 8'd0);
        chk("deq_empty_err", 32'(o_err), 32'd1);
        chk("deq_empty_valid", 32'(o_valid), 32'd0);
        step();
        chk("deq_empty_err_pulse", 32'(o_err), 32'd0);
        chk("deq_empty_size", 32'(o_size), 32'd0);

        // Child tie: {1,4,4}.
        do_reset();
        enq(8'd1); enq(8'd4); enq(8'd4);
        issue(1'b1, 8'd0);
        chk("tie_data", 32'(o_data), 32'd1);
        wait_idle(busy);
        chk("tie_mem0", 32'(dut.mem[0]), 32'd4);
        chk("tie_mem1", 32'(dut.mem[1]), 32'd4);
        chk("tie_size", 32'(o_size), 32'd2);
        chk("tie_min", 32'(o_min), 32'd4);

        // Fill to capacity, then enqueue when full.
        do_reset();
        for (int k = 0; k < CAP; k++) enq(8'($urandom_range(0, 200)));
        chk("full_flag", 32'(o_full), 32'd1);
        issue(1'b0, 8'd0);
        chk("full_err", 32'(o_err), 32'd1);
        chk("full_size", 32'(o_size), 32'(CAP));
        step();
        chk("full_err_pulse", 32'(o_err), 32'd0);
        chk("full_mem0", 32'(dut.mem[0]), 32'(model_min()));
        chk("full_min", 32'(o_min), 32'(model_min()));

        // Reset while in DN_RDR.
        do_reset();
        enq(8'd1); enq(8'd2); enq(8'd3); enq(8'd4);
        issue(1'b1, 8'd0);   // now in DN_LAST
        step();              // DN_RDL
        step();              // DN_RDR
        chk("mid_busy", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_size", 32'(o_size), 32'd0);
        chk("mid_rst_empty", 32'(o_empty), 32'd1);
        step();
        i_rst_n = 1'b1;
        model.delete();
        issue(1'b0, 8'd8);
        chk("mid_rst_min", 32'(o_min), 32'd8);
        chk("mid_rst_size1", 32'(o_size), 32'd1);

        // Randomized stream: fill-biased, balanced, then drain-biased.
        do_reset();
        for (int k = 0; k < 60; k++)  rand_op(75);
        for (int k = 0; k < 80; k++)  rand_op(50);
        for (int k = 0; k < 60; k++)  rand_op(25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
